alien_fire_scheduler: RTL and testbench
=======================================

Name: alien_fire_scheduler

Overview:
Decides when and from which alien a rocket is fired, and which free alien rocket slot receives it. Counts down a frame-based cooldown, then scans the alien matrix bottom-up through the alien-matrix read port, starting at a random column. On the first live alien it emits one launch pulse with position, speed and a one-hot slot. Sits between the alien matrix, the random generator and the single-rocket controllers.

Parameters:
COLS, 14, alien matrix columns
ROWS, 6, alien matrix rows
SLOTS, 3, alien rocket slots
CELL, 32, alien cell pitch in pixels (power of 2)
COOLDOWN_FRAMES, 15, frames between fire attempts

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
startOfFrame  in  1  one-cycle pulse per frame
enable  in  1  game running; low suspends firing
randCol  in  4  random start column
randSpeed  in  2  random speed index
aliensTLX  in  11 signed  matrix top-left X
aliensTLY  in  11 signed  matrix top-left Y
slotActive  in  SLOTS  busy flags from the rocket controllers
alienAlive  in  1  alive bit for (colIdx,rowIdx); valid 1 cycle after the address
colIdx  out  4  matrix read column
rowIdx  out  3  matrix read row
launch  out  1  one-cycle fire pulse
launchSlot  out  SLOTS  one-hot slot, valid with launch
launchX  out  11 signed  rocket initial X
launchY  out  11 signed  rocket initial Y
launchSpeed  out  11 signed  rocket initial speed
busy  out  1  high in SCAN, WAIT and LAUNCH

Behaviour:
- Reset: state IDLE; cooldown=COOLDOWN_FRAMES; colIdx=0, rowIdx=0. launch, launchSlot, launchX, launchY, launchSpeed and busy are all 0.
- States: IDLE, COOLDOWN, SCAN, WAIT, LAUNCH.
- IDLE: when enable=1, go to COOLDOWN.
- COOLDOWN: on each startOfFrame, decrement cooldown if it is nonzero. When cooldown=0 and at least one slotActive bit is 0:
  - colIdx = randCol if randCol<COLS, else randCol-COLS.
  - rowIdx = ROWS-1.
  - Clear the visited-column count, then go to SCAN.
  - If all slots are busy, stay in COOLDOWN with cooldown=0 and retry every cycle.
- SCAN: the address is on colIdx/rowIdx; go to WAIT.
- WAIT: sample alienAlive.
  - Alive: register launch values and go to LAUNCH.
  - Dead, rowIdx>0: decrement rowIdx, go to SCAN.
  - Dead, rowIdx=0: advance colIdx (COLS-1 wraps to 0), set rowIdx=ROWS-1, increment the visited count.
  - Visited count = COLS (empty matrix): reload cooldown, go to COOLDOWN, no launch.
- Each cell costs 2 cycles. A full scan takes at most 2*COLS*ROWS = 168 cycles.
- Launch values, computed in WAIT at full 11-bit signed width with wrap-around (no saturation):
  - launchX = aliensTLX + CELL*colIdx + CELL/2
  - launchY = aliensTLY + CELL*rowIdx + CELL
  - launchSpeed = {32,64,128,256}[randSpeed], always positive (downward)
- LAUNCH lasts 1 cycle.
  - Re-sample slotActive and take the lowest-index free slot.
  - If one is free: launch=1 and launchSlot is one-hot for that cycle.
  - If all slots filled during the scan: no pulse.
  - Either way, reload cooldown and return to COOLDOWN.
- launchX, launchY and launchSpeed hold their values until the next launch.
- enable=0 in any state: go to IDLE next cycle and abort any scan without a launch. The cooldown value is held.
- startOfFrame arriving during SCAN, WAIT or LAUNCH is ignored.
- At most one launch per cooldown period. launch is never asserted two cycles in a row.
- A reset asserted mid-scan returns every register to its reset value immediately.

Optional Feature:
AIM_AT_PLAYER_EN
- Defined: adds input playerCenterX (11 signed).
  - Start column = (playerCenterX - aliensTLX) / CELL, clamped to 0..COLS-1. A negative difference gives 0.
  - randCol is ignored.
- Not defined: start column comes from randCol as above; the port is absent.

Test Plan:
1. Reset high, then low with enable=1, matrix all alive, randCol=3, randSpeed=2, TLX=100, TLY=50 -> after 15 startOfFrame pulses, launch at (col 3, row 5): launchX=212, launchY=242, launchSpeed=128, launchSlot=001. busy returns to 0.
2. Column 13 empty, column 0 row 2 alive, randCol=13 -> scan wraps to column 0. Launch at row 2, launchX=TLX+16.
3. randCol=15 -> scan starts at column 1. Check colIdx=1 on the first SCAN cycle.
4. slotActive=011 -> launchSlot=100. slotActive=111 at cooldown expiry -> no scan until a slot frees, then a launch within 170 cycles.
5. Matrix all dead -> no launch after 168 scan cycles; cooldown is reloaded and the next attempt comes 15 frames later.
6. Drop enable mid-scan, then pulse reset mid-scan -> no launch. After reset, all outputs are 0 and the state is IDLE.

Source files
------------

// File: rtl/alien_fire_scheduler_if.sv
// Alien fire scheduler bundle: game inputs, matrix read port, launch outputs.
// playerCenterX exists only when AIM_AT_PLAYER_EN is defined.
interface alien_fire_scheduler_if #(
  parameter int SLOTS = 3
);
  logic               startOfFrame;
  logic               enable;
  logic [3:0]         randCol;
  logic [1:0]         randSpeed;
  logic signed [10:0] aliensTLX;
  logic signed [10:0] aliensTLY;
  logic [SLOTS-1:0]   slotActive;
  logic               alienAlive;
  logic [3:0]         colIdx;
  logic [2:0]         rowIdx;
  logic               launch;
  logic [SLOTS-1:0]   launchSlot;
  logic signed [10:0] launchX;
  logic signed [10:0] launchY;
  logic signed [10:0] launchSpeed;
  logic               busy;

`ifdef AIM_AT_PLAYER_EN
  logic signed [10:0] playerCenterX;

  modport master (
    output playerCenterX,
    output startOfFrame, enable, randCol, randSpeed,
    output aliensTLX, aliensTLY, slotActive, alienAlive,
    input  colIdx, rowIdx, launch, launchSlot,
    input  launchX, launchY, launchSpeed, busy
  );

  modport slave (
    input  playerCenterX,
    input  startOfFrame, enable, randCol, randSpeed,
    input  aliensTLX, aliensTLY, slotActive, alienAlive,
    output colIdx, rowIdx, launch, launchSlot,
    output launchX, launchY, launchSpeed, busy
  );
`else
  modport master (
    output startOfFrame, enable, randCol, randSpeed,
    output aliensTLX, aliensTLY, slotActive, alienAlive,
    input  colIdx, rowIdx, launch, launchSlot,
    input  launchX, launchY, launchSpeed, busy
  );

  modport slave (
    input  startOfFrame, enable, randCol, randSpeed,
    input  aliensTLX, aliensTLY, slotActive, alienAlive,
    output colIdx, rowIdx, launch, launchSlot,
    output launchX, launchY, launchSpeed, busy
  );
`endif
endinterface

// File: rtl/alien_fire_scheduler.sv
// Alien fire scheduler: frame cooldown, bottom-up matrix scan, rocket slot pick.
// Define AIM_AT_PLAYER_EN to start the scan at the column under the player.
module alien_fire_scheduler #(
  parameter int COLS            = 14,
  parameter int ROWS            = 6,
  parameter int SLOTS           = 3,
  parameter int CELL            = 32,
  parameter int COOLDOWN_FRAMES = 15
) (
  input logic                   clk,
  input logic                   reset,
  alien_fire_scheduler_if.slave bus
);
  localparam int CW  = $clog2(COOLDOWN_FRAMES + 1);
  localparam int VW  = $clog2(COLS + 1);
  localparam int CSH = $clog2(CELL);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_COOL   = 3'd1;
  localparam logic [2:0] S_SCAN   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_LAUNCH = 3'd4;

  logic [2:0]    r_state;
  logic [CW-1:0] r_cool;
  logic [3:0]    r_col;
  logic [2:0]    r_row;
  logic [VW-1:0] r_visited;
  logic [10:0]   r_x;
  logic [10:0]   r_y;
  logic [10:0]   r_spd;

  logic [2:0]       w_state_nx;
  logic [CW-1:0]    w_cool_nx;
  logic [3:0]       w_col_nx;
  logic [2:0]       w_row_nx;
  logic [VW-1:0]    w_vis_nx;
  logic             w_ld;
  logic             w_free;
  logic [SLOTS-1:0] w_slot;
  logic [3:0]       w_start;
  logic [10:0]      w_lx;
  logic [10:0]      w_ly;
  logic [10:0]      w_spd;

  // lowest clear bit of slotActive, zero when every slot is taken
  assign w_free = ~&bus.slotActive;
  assign w_slot = ~bus.slotActive
                & (bus.slotActive + SLOTS'(1));

`ifdef AIM_AT_PLAYER_EN
  logic signed [11:0] w_diff;
  logic [11:0]        w_q;

  assign w_diff = {bus.playerCenterX[10], bus.playerCenterX}
                - {bus.aliensTLX[10], bus.aliensTLX};
  assign w_q    = w_diff >> CSH;

  always_comb begin
    w_start = '0;
    if (!w_diff[11]) begin
      if (w_q >= 12'(COLS)) w_start = 4'(COLS - 1);
      else                  w_start = w_q[3:0];
    end
  end
`else
  always_comb begin
    w_start = bus.randCol;
    if (bus.randCol >= 4'(COLS))
      w_start = bus.randCol - 4'(COLS);
  end
`endif

  // rocket leaves from the bottom-centre of the alien cell
  assign w_lx = bus.aliensTLX
              + (11'(r_col) << CSH)
              + 11'(CELL / 2);
  assign w_ly = bus.aliensTLY
              + (11'(r_row) << CSH)
              + 11'(CELL);

  always_comb begin
    w_spd = 11'd32;
    unique case (bus.randSpeed)
      2'd0: w_spd = 11'd32;
      2'd1: w_spd = 11'd64;
      2'd2: w_spd = 11'd128;
      2'd3: w_spd = 11'd256;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    w_cool_nx  = r_cool;
    w_col_nx   = r_col;
    w_row_nx   = r_row;
    w_vis_nx   = r_visited;
    w_ld       = 1'b0;
    if (!bus.enable) begin
      w_state_nx = S_IDLE;
    end else begin
      unique case (1'b1)
        r_state == S_IDLE: begin
          w_state_nx = S_COOL;
        end
        r_state == S_COOL: begin
          if (r_cool == '0) begin
            if (w_free) begin
              w_col_nx   = w_start;
              w_row_nx   = 3'(ROWS - 1);
              w_vis_nx   = '0;
              w_state_nx = S_SCAN;
            end
          end else if (bus.startOfFrame) begin
            w_cool_nx = r_cool - CW'(1);
          end
        end
        r_state == S_SCAN: begin
          w_state_nx = S_WAIT;
        end
        r_state == S_WAIT: begin
          if (bus.alienAlive) begin
            w_ld       = 1'b1;
            w_state_nx = S_LAUNCH;
          end else if (r_row != '0) begin
            w_row_nx   = r_row - 3'd1;
            w_state_nx = S_SCAN;
          end else begin
            if (r_col == 4'(COLS - 1)) w_col_nx = '0;
            else                       w_col_nx = r_col + 4'd1;
            w_row_nx   = 3'(ROWS - 1);
            w_vis_nx   = r_visited + VW'(1);
            w_state_nx = S_SCAN;
            // every column visited: empty matrix, give up
            if (r_visited == VW'(COLS - 1)) begin
              w_cool_nx  = CW'(COOLDOWN_FRAMES);
              w_state_nx = S_COOL;
            end
          end
        end
        r_state == S_LAUNCH: begin
          w_cool_nx  = CW'(COOLDOWN_FRAMES);
          w_state_nx = S_COOL;
        end
        default: begin
          w_state_nx = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cool    <= CW'(COOLDOWN_FRAMES);
      r_col     <= '0;
      r_row     <= '0;
      r_visited <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_spd     <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_cool    <= w_cool_nx;
      r_col     <= w_col_nx;
      r_row     <= w_row_nx;
      r_visited <= w_vis_nx;
      if (w_ld) begin
        r_x   <= w_lx;
        r_y   <= w_ly;
        r_spd <= w_spd;
      end
    end
  end

  assign bus.colIdx      = r_col;
  assign bus.rowIdx      = r_row;
  assign bus.launch      = (r_state == S_LAUNCH) & w_free;
  assign bus.launchSlot  = (r_state == S_LAUNCH) ? w_slot : '0;
  assign bus.launchX     = r_x;
  assign bus.launchY     = r_y;
  assign bus.launchSpeed = r_spd;
  assign bus.busy        = (r_state == S_SCAN)
                         | (r_state == S_WAIT)
                         | (r_state == S_LAUNCH);
endmodule

// File: tb/tb_alien_fire_scheduler.sv
// Bench for alien_fire_scheduler: vector table, random attempts, corner sequences.
// Attempts are predicted at transaction level from the scan rules.
module tb_alien_fire_scheduler;
  localparam int COLS  = 14;
  localparam int ROWS  = 6;
  localparam int SLOTS = 3;
  localparam int FRAME = 8;
  localparam int NCELL = COLS * ROWS;

  typedef logic [NCELL-1:0] mat_t;

  typedef struct {
    mat_t       mat;
    logic [3:0] rcol;
    logic [1:0] rspd;
    int         tlx;
    int         tly;
    logic [2:0] slots;
    bit         exp_l;
    int         exp_col;
    int         exp_x;
    int         exp_y;
    int         exp_spd;
    logic [2:0] exp_slot;
    int         exp_busy;
  } vec_t;

  typedef struct {
    int         bl;
    bit         got;
    logic [2:0] slot;
    int         x;
    int         y;
    int         spd;
  } obs_t;

  localparam mat_t ALL  = '1;
  localparam mat_t NONE = '0;
  localparam mat_t C13  = {6'h3F, 78'd0};

  logic clk = 1'b0;
  logic reset;
  mat_t r_mat;
  bit   sof_run = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   nl = 0;
  int   consec = 0;
  bit   prev_l = 1'b0;

  alien_fire_scheduler_if #(.SLOTS(SLOTS)) bus ();

  alien_fire_scheduler #(
    .COLS(COLS),
    .ROWS(ROWS),
    .SLOTS(SLOTS),
    .CELL(32),
    .COOLDOWN_FRAMES(15)
  ) u_dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // matrix RAM: alive bit valid one cycle after the address
  always @(posedge clk) begin
    if (int'(bus.colIdx) * ROWS + int'(bus.rowIdx) < NCELL)
      bus.alienAlive <= r_mat[int'(bus.colIdx) * ROWS + int'(bus.rowIdx)];
    else
      bus.alienAlive <= 1'b0;
  end

  initial begin
    int c;
    c = 0;
    bus.startOfFrame = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (sof_run) begin
        c = (c + 1) % FRAME;
        bus.startOfFrame = (c == 0);
      end else begin
        c = 0;
        bus.startOfFrame = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.launch) nl++;
    if (bus.launch && prev_l) consec++;
    prev_l = bus.launch;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int wrap11(input int a);
    int r;
    r = a & 2047;
    if (r >= 1024) r -= 2048;
    return r;
  endfunction

  function automatic vec_t mk(
    input mat_t m, input int rc, input int rs,
    input int tx, input int ty, input logic [2:0] sl,
    input bit l, input int col, input int x, input int y,
    input int sp, input logic [2:0] es, input int bl
  );
    vec_t v;
    v.mat = m;      v.rcol = 4'(rc);   v.rspd = 2'(rs);
    v.tlx = tx;     v.tly = ty;        v.slots = sl;
    v.exp_l = l;    v.exp_col = col;   v.exp_x = x;
    v.exp_y = y;    v.exp_spd = sp;    v.exp_slot = es;
    v.exp_busy = bl;
    return v;
  endfunction

  // first live alien, scanning columns from the start, bottom row upward
  function automatic vec_t predict(input vec_t v);
    int  c;
    int  cells;
    bit  found;
    cells = 0;
    found = 1'b0;
    v.exp_x = 0;
    v.exp_y = 0;
    v.exp_col = (v.rcol < COLS) ? int'(v.rcol) : int'(v.rcol) - COLS;
    for (int k = 0; k < COLS && !found; k++) begin
      c = (v.exp_col + k) % COLS;
      for (int r = ROWS - 1; r >= 0 && !found; r--) begin
        cells++;
        if (v.mat[c * ROWS + r]) begin
          found = 1'b1;
          v.exp_x = wrap11(v.tlx + 32 * c + 16);
          v.exp_y = wrap11(v.tly + 32 * r + 32);
        end
      end
    end
    v.exp_l = found;
    v.exp_spd = 32 << v.rspd;
    v.exp_busy = found ? 2 * cells + 1 : 2 * NCELL;
    v.exp_slot = '0;
    for (int s = SLOTS - 1; s >= 0; s--)
      if (!v.slots[s]) v.exp_slot = 3'(1 << s);
    return v;
  endfunction

  task automatic enable_on();
    bus.enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_rise(input int bound, output int sofs);
    sofs = 0;
    for (int n = 0; n < bound && !bus.busy; n++) begin
      if (bus.startOfFrame) sofs++;
      @(negedge clk);
    end
  endtask

  task automatic drain(output obs_t o);
    o = '{default: 0};
    for (int n = 0; n < 200 && bus.busy; n++) begin
      o.bl++;
      if (bus.launch) begin
        o.got  = 1'b1;
        o.slot = bus.launchSlot;
        o.x    = int'(bus.launchX);
        o.y    = int'(bus.launchY);
        o.spd  = int'(bus.launchSpeed);
      end
      @(negedge clk);
    end
  endtask

  task automatic apply(input vec_t v);
    r_mat = v.mat;
    bus.randCol = v.rcol;
    bus.randSpeed = v.rspd;
    bus.aliensTLX = 11'(v.tlx);
    bus.aliensTLY = 11'(v.tly);
    bus.slotActive = v.slots;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int   sofs;
    obs_t o;
    apply(v);
    wait_rise(20 * FRAME, sofs);
    chk({nm, ".rise"}, int'(bus.busy), 1);
    if (!bus.busy) return;
    chk({nm, ".frames"}, sofs, 15);
    chk({nm, ".col0"}, int'(bus.colIdx), v.exp_col);
    chk({nm, ".row0"}, int'(bus.rowIdx), ROWS - 1);
    drain(o);
    chk({nm, ".fall"}, int'(bus.busy), 0);
    chk({nm, ".busylen"}, o.bl, v.exp_busy);
    chk({nm, ".launch"}, int'(o.got), int'(v.exp_l));
    if (v.exp_l) begin
      chk({nm, ".slot"}, int'(o.slot), int'(v.exp_slot));
      chk({nm, ".x"}, o.x, v.exp_x);
      chk({nm, ".y"}, o.y, v.exp_y);
      chk({nm, ".spd"}, o.spd, v.exp_spd);
    end
  endtask

  initial begin
    vec_t tbl[5];
    vec_t v;
    obs_t o;
    int   sofs;
    int   nl0;
    int   cnt;

    tbl[0] = mk(ALL, 3, 2, 100, 50, 3'b000,
                1, 3, 212, 242, 128, 3'b001, 3);
    tbl[1] = mk(mat_t'(4), 13, 0, 100, 50, 3'b000,
                1, 13, 116, 146, 32, 3'b001, 21);
    tbl[2] = mk(ALL, 15, 3, -200, -100, 3'b011,
                1, 1, -152, 92, 256, 3'b100, 3);
    tbl[3] = mk(NONE, 7, 1, 0, 0, 3'b000,
                0, 7, 0, 0, 0, 3'b000, 168);
    tbl[4] = mk(C13, 13, 1, 1000, 1000, 3'b101,
                1, 13, -616, -856, 64, 3'b010, 3);

    reset = 1'b1;
    bus.enable = 1'b0;
    apply(tbl[0]);
    repeat (3) @(negedge clk);
    chk("rst.busy", int'(bus.busy), 0);
    chk("rst.launch", int'(bus.launch), 0);
    chk("rst.slot", int'(bus.launchSlot), 0);
    chk("rst.col", int'(bus.colIdx), 0);
    chk("rst.row", int'(bus.rowIdx), 0);
    chk("rst.x", int'(bus.launchX), 0);
    chk("rst.y", int'(bus.launchY), 0);
    chk("rst.spd", int'(bus.launchSpeed), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle.busy", int'(bus.busy), 0);

    enable_on();
    sof_run = 1'b1;
    for (int i = 0; i < 5; i++)
      run_vec(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 8; i++) begin
      v = tbl[0];
      for (int b = 0; b < NCELL; b++)
        v.mat[b] = ($urandom_range(0, 15) == 0);
      if (i == 3) v.mat = NONE;
      v.rcol = 4'($urandom_range(0, 15));
      v.rspd = 2'($urandom_range(0, 3));
      v.tlx = int'($urandom_range(0, 2047)) - 1024;
      v.tly = int'($urandom_range(0, 2047)) - 1024;
      v.slots = 3'($urandom_range(0, 6));
      v = predict(v);
      run_vec(v, $sformatf("rnd%0d", i));
    end

    // slots fill up while scanning: no pulse, cooldown reloaded
    apply(mk(mat_t'(1) << 12, 0, 0, 100, 50, 3'b110,
             0, 0, 0, 0, 0, 3'b000, 0));
    wait_rise(20 * FRAME, sofs);
    chk("full.rise", int'(bus.busy), 1);
    bus.slotActive = 3'b111;
    drain(o);
    chk("full.busylen", o.bl, 37);
    chk("full.launch", int'(o.got), 0);

    // every slot busy at expiry: no scan until one frees
    wait_rise(16 * FRAME + 4, sofs);
    chk("stall.noscan", int'(bus.busy), 0);
    r_mat = ALL;
    bus.randCol = 4'd0;
    bus.slotActive = 3'b101;
    wait_rise(170, sofs);
    chk("stall.rise", int'(bus.busy), 1);
    drain(o);
    chk("stall.launch", int'(o.got), 1);
    chk("stall.slot", int'(o.slot), 2);
    chk("stall.x", o.x, 116);
    chk("stall.y", o.y, 242);

    // enable drop mid-scan: abort, cooldown stays expired
    r_mat = NONE;
    bus.slotActive = 3'b000;
    wait_rise(20 * FRAME, sofs);
    chk("abort.rise", int'(bus.busy), 1);
    chk("abort.frames", sofs, 15);
    nl0 = nl;
    repeat (20) @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    chk("abort.busy", int'(bus.busy), 0);
    cnt = 0;
    repeat (3 * FRAME) begin
      @(negedge clk);
      if (bus.busy) cnt++;
    end
    chk("abort.idle", cnt, 0);
    chk("abort.nolaunch", nl - nl0, 0);
    r_mat = ALL;
    bus.randCol = 4'd5;
    bus.enable = 1'b1;
    wait_rise(4, sofs);
    chk("resume.rise", int'(bus.busy), 1);
    chk("resume.col", int'(bus.colIdx), 5);
    drain(o);
    chk("resume.launch", int'(o.got), 1);
    chk("resume.x", o.x, 276);

    // reset mid-scan clears every register at once
    r_mat = NONE;
    wait_rise(20 * FRAME, sofs);
    chk("rstscan.rise", int'(bus.busy), 1);
    nl0 = nl;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    bus.enable = 1'b0;
    #1;
    chk("rstscan.busy", int'(bus.busy), 0);
    chk("rstscan.col", int'(bus.colIdx), 0);
    chk("rstscan.row", int'(bus.rowIdx), 0);
    chk("rstscan.x", int'(bus.launchX), 0);
    chk("rstscan.spd", int'(bus.launchSpeed), 0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (2 * FRAME) begin
      @(negedge clk);
      if (bus.busy) cnt++;
    end
    chk("rstscan.idle", cnt, 0);
    chk("rstscan.nolaunch", nl - nl0, 0);
    enable_on();
    run_vec(mk(ALL, 4, 0, 0, 0, 3'b000,
               1, 4, 144, 192, 32, 3'b001, 3), "post");

    chk("launch.b2b", consec, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
